// File: rtl/rice_core_pipeline_buffer.sv
// Valid/ready inter-stage buffer: circular FIFO of DEPTH words with optional
// zero-latency bypass when empty and a flush that discards all content.
module rice_core_pipeline_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 2,
  parameter int BYPASS     = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_flush,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [DATA_WIDTH-1:0]        i_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic             BYP      = (BYPASS != 0);

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0]      count_q, count_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic                  empty, push, pop, push_st, pop_st;

  always_comb begin
    empty   = (count_q == '0);
    o_ready = (count_q < DEPTH_C);
    o_valid = ~i_flush & (~empty | (BYP & i_valid));
    o_data  = ~empty ? mem_q[rd_ptr_q] : (BYP ? i_data : '0);
    o_count = count_q;
    push    = i_valid & o_ready & ~i_flush;
    pop     = o_valid & i_ready;
    // A pop while empty can only be a bypass beat: it never touches storage.
    push_st = push & ~(empty & pop);
    pop_st  = pop & ~empty;
  end

  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (i_flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push_st) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_st)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_st, pop_st})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage is data only; its contents are don't-care after reset.
  always_ff @(posedge i_clk) begin
    if (push_st) mem_q[wr_ptr_q] <= i_data;
  end

`ifndef SYNTHESIS
  a_count_bound: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    count_q <= DEPTH_C);
  a_no_push_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(push_st && (count_q == DEPTH_C)));
  a_hold_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (o_valid && !i_ready && !empty) |=> (i_flush || (o_valid && $stable(o_data))));
`endif

endmodule
